// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: ID/EX-side request and EX/MEM-side result bundle for the M-extension unit
interface ex_muldiv_unit_if #(parameter int DATAWIDTH = 32);
   logic start;
   logic flush;
   logic stall;
   logic done;
   logic [2:0] funct3;
   logic [DATAWIDTH-1:0] op_a;
   logic [DATAWIDTH-1:0] op_b;
   logic [DATAWIDTH-1:0] result;
   modport master (output start, funct3, op_a, op_b, flush, input stall, done, result);
   modport slave (input start, funct3, op_a, op_b, flush, output stall, done, result);
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multi-cycle RV32M multiply/divide; define MULDIV_FAST_MUL_EN for a single-cycle multiply path
module ex_muldiv_unit #(
   parameter int DATAWIDTH = 32,
   parameter int CNTW = 6
) (
   input logic clk,
   input logic rst,
   ex_muldiv_unit_if.slave bus
);
   localparam int W = DATAWIDTH;
   localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_n;
   logic [CNTW-1:0] cnt, cnt_n;
   logic [2:0] f3, f3_n;
   logic sgn, sgn_n;
   logic [W-1:0] mb, mb_n, rem, rem_n, res, res_n, ma, mbv, rem_step, spec_res;
   logic [2*W-1:0] acc, acc_n, acc_step;
   logic [W:0] sum, rsh;
   logic a_s, b_s, sa, sb, sg_in, ge, special;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*W-1:0] fp;
   assign fp = {{W{1'b0}}, ma} * {{W{1'b0}}, mbv};
`endif

   function automatic logic [W-1:0] pick(input logic [2*W-1:0] raw, input logic sg, input logic [2:0] f);
      logic [2*W-1:0] v;
      v = sg ? -raw : raw;
      return (f[2] | f[1:0] == 2'b00) ? v[W-1:0] : v[2*W-1:W];
   endfunction

   assign a_s = bus.funct3[2] ? ~bus.funct3[0] : bus.funct3[1:0] != 2'b11;
   assign b_s = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
   assign sa = a_s & bus.op_a[W-1];
   assign sb = b_s & bus.op_b[W-1];
   assign ma = sa ? -bus.op_a : bus.op_a;
   assign mbv = sb ? -bus.op_b : bus.op_b;
   assign sg_in = sa ^ (sb & ~(bus.funct3[2] & bus.funct3[1]));
   assign special = bus.funct3[2] & (bus.op_b == '0 | (~bus.funct3[0] & bus.op_a == MIN & bus.op_b == '1));
   assign spec_res = bus.op_b == '0 ? (bus.funct3[1] ? bus.op_a : '1) : (bus.funct3[1] ? '0 : MIN);
   assign sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mb} : '0);
   assign rsh = {rem, acc[W-1]};
   assign ge = rsh >= {1'b0, mb};
   assign rem_step = ge ? rsh[W-1:0] - mb : rsh[W-1:0];
   assign acc_step = f3[2] ? {acc[2*W-1:W], acc[W-2:0], ge} : {sum, acc[W-1:1]};
   assign bus.stall = (state == IDLE & bus.start & ~bus.flush) | state == CALC;
   assign bus.done = state == DONE;
   assign bus.result = res;

   // next state: mul keeps the multiplicand in mb and multiplier in acc; div keeps divisor in mb, dividend/quotient in acc
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      f3_n = f3;
      sgn_n = sgn;
      mb_n = mb;
      acc_n = acc;
      rem_n = rem;
      res_n = res;
      if (bus.flush) begin
         state_n = IDLE;
         cnt_n = '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               f3_n = bus.funct3;
               sgn_n = sg_in;
               cnt_n = '0;
               if (special) begin
                  state_n = DONE;
                  res_n = spec_res;
               end
`ifdef MULDIV_FAST_MUL_EN
               else if (~bus.funct3[2]) begin
                  state_n = DONE;
                  res_n = pick(fp, sg_in, bus.funct3);
               end
`endif
               else begin
                  state_n = CALC;
                  mb_n = bus.funct3[2] ? mbv : ma;
                  acc_n = {{W{1'b0}}, bus.funct3[2] ? ma : mbv};
                  rem_n = '0;
               end
            end
            CALC: begin
               acc_n = acc_step;
               rem_n = rem_step;
               cnt_n = cnt + CNTW'(1);
               if (cnt == CNTW'(W-1)) begin
                  state_n = DONE;
                  res_n = pick(f3[2] ? {{W{1'b0}}, f3[1] ? rem_step : acc_step[W-1:0]} : acc_step, sgn, f3);
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         f3 <= '0;
         sgn <= 1'b0;
         mb <= '0;
         acc <= '0;
         rem <= '0;
         res <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         f3 <= f3_n;
         sgn <= sgn_n;
         mb <= mb_n;
         acc <= acc_n;
         rem <= rem_n;
         res <= res_n;
      end
   end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: vector table, random ops against a reference model, flush/reset/back-to-back sequences
module tb_ex_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
   localparam int ML = 1;
`else
   localparam int ML = 33;
`endif
   localparam int DL = 33;
   typedef struct {
      logic [2:0] f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;
   logic [31:0] sb_q[$];
   logic [31:0] last_res = '0;
   vec_t tv[21];

   ex_muldiv_unit_if #(.DATAWIDTH(32)) bus ();
   ex_muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", nm, act, exp);
   endtask

   function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] xa, xb, ua, ub, p;
      xa = {{32{a[31]}}, a};
      xb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (f)
         3'b000, 3'b001: p = xa * xb;
         3'b010: p = xa * ub;
         3'b011: p = ua * ub;
         3'b100: p = (b == 0) ? -64'sd1 : xa / xb;
         3'b101: p = (b == 0) ? -64'sd1 : ua / ub;
         3'b110: p = (b == 0) ? xa : xa % xb;
         default: p = (b == 0) ? ua : ua % ub;
      endcase
      return (f == 3'b001 || f == 3'b010 || f == 3'b011) ? p[63:32] : p[31:0];
   endfunction

   task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, output int dcyc);
      int t0, st;
      bit got;
      logic [31:0] e;
      bus.start = 1'b1;
      bus.funct3 = f;
      bus.op_a = a;
      bus.op_b = b;
      sb_q.push_back(exp);
      #1;
      t0 = cyc;
      st = int'(bus.stall);
      got = 1'b0;
      dcyc = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         st += int'(bus.stall);
         if (bus.done) begin
            got = 1'b1;
            dcyc = cyc;
            e = sb_q.pop_front();
            chk({nm, " result"}, bus.result, e);
            chk({nm, " latency"}, 32'(cyc - t0), 32'(lat));
            chk({nm, " stall cycles"}, 32'(st), 32'(lat));
            last_res = e;
         end
         bus.start = 1'b0;
      end
      if (!got) begin
         void'(sb_q.pop_front());
         chk({nm, " done timeout"}, 32'd0, 32'd1);
      end
      @(negedge clk);
      chk({nm, " done one-shot"}, 32'(bus.done), 32'd0);
      chk({nm, " result hold"}, bus.result, last_res);
   endtask

   initial begin
      int d1, d2;
      bit seen;
      logic [2:0] f;
      logic [31:0] a, b;
      tv[0] = '{3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, ML};
      tv[1] = '{3'b001, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, ML};
      tv[2] = '{3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, ML};
      tv[3] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, ML};
      tv[4] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, ML};
      tv[5] = '{3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, ML};
      tv[6] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ML};
      tv[7] = '{3'b100, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFD, DL};
      tv[8] = '{3'b110, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFE, DL};
      tv[9] = '{3'b101, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, DL};
      tv[10] = '{3'b100, 32'd20, 32'hFFFFFFFA, 32'hFFFFFFFD, DL};
      tv[11] = '{3'b110, 32'd20, 32'hFFFFFFFA, 32'd2, DL};
      tv[12] = '{3'b111, 32'd100, 32'd7, 32'd2, DL};
      tv[13] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0, DL};
      tv[14] = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, DL};
      tv[15] = '{3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1};
      tv[16] = '{3'b111, 32'd5, 32'd0, 32'd5, 1};
      tv[17] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
      tv[18] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1};
      tv[19] = '{3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1};
      tv[20] = '{3'b110, 32'd7, 32'd0, 32'd7, 1};
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.funct3 = '0;
      bus.op_a = '0;
      bus.op_b = '0;
      repeat (3) @(negedge clk);
      chk("reset stall", 32'(bus.stall), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset result", bus.result, 32'd0);
      rst = 1'b0;
      foreach (tv[i]) run_op($sformatf("vec%0d", i), tv[i].f, tv[i].a, tv[i].b, tv[i].exp, tv[i].lat, d1);
      for (int i = 0; i < 8; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
         run_op($sformatf("rand%0d", i), f, a, b, ref_op(f, a, b),
                (f[2] && (b == 0)) ? 1 : (f[2] ? DL : ML), d1);
      end
      run_op("pre-flush", 3'b101, 32'd100, 32'd7, 32'd14, DL, d1);
      bus.start = 1'b1;
      bus.funct3 = 3'b101;
      bus.op_a = 32'd1000;
      bus.op_b = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      chk("flush stall", 32'(bus.stall), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         seen |= bus.done;
         @(negedge clk);
      end
      chk("flush no done", 32'(seen), 32'd0);
      chk("flush result kept", bus.result, 32'd14);
      run_op("post-flush", 3'b100, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, DL, d1);
      bus.start = 1'b1;
      bus.funct3 = 3'b100;
      bus.op_a = 32'd77;
      bus.op_b = 32'd5;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst mid stall", 32'(bus.stall), 32'd0);
      chk("rst mid done", 32'(bus.done), 32'd0);
      chk("rst mid result", bus.result, 32'd0);
      last_res = '0;
      run_op("b2b first", 3'b101, 32'd1000, 32'd3, 32'd333, DL, d1);
      run_op("b2b second", 3'b101, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, DL, d2);
      chk("b2b spacing", 32'(d2 - d1), 32'd34);
      chk("scoreboard empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
